// File: rtl/pll_reset_sequencer.sv
// Power-up sequencer for an SB_PLL40_CORE: pulses RESETB, waits for a stable LOCK, then releases
// the PLL-domain reset. Define LOCK_TIMEOUT_EN to retry the PLL when lock does not arrive in time.
module pll_reset_sequencer #(
  parameter int unsigned RESET_CYCLES   = 16,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 65536,
  parameter int unsigned CNT_W          = 17
) (
  input  logic       clock_in,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       restart_req,
  output logic       pll_resetb,
  output logic       sys_reset_n,
  output logic       ready,
  output logic [1:0] state,
  output logic [7:0] loss_count
);

  typedef enum logic [1:0] {
    PLL_RESET = 2'b00,
    WAIT_LOCK = 2'b01,
    STABLE    = 2'b10,
    RUN       = 2'b11
  } state_e;

  localparam longint unsigned CNT_SPAN = 64'd1 << CNT_W;
  localparam logic [CNT_W-1:0] RESET_LAST  = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

  // The shared counter must be able to reach every programmed terminal count.
  if (RESET_CYCLES == 0 || STABLE_CYCLES == 0 || TIMEOUT_CYCLES == 0 ||
      64'(RESET_CYCLES) >= CNT_SPAN || 64'(STABLE_CYCLES) >= CNT_SPAN ||
      64'(TIMEOUT_CYCLES) >= CNT_SPAN) begin : g_param_check
    $error("pll_reset_sequencer: cycle parameters must be >= 1 and < 2**CNT_W");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       loss_d;
  logic             lock_meta, lock_s;
  logic             timeout_hit;

  // LOCK comes from the PLL's own analog loop, unrelated to clock_in.
  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      lock_s    <= lock_meta;
    end
  end

`ifdef LOCK_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  assign timeout_hit = (cnt_q == TIMEOUT_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    loss_d  = loss_count;
    if (restart_req) begin
      state_d = PLL_RESET;
      cnt_d   = '0;
    end else begin
      case (state_q)
        PLL_RESET: begin
          if (cnt_q == RESET_LAST) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        WAIT_LOCK: begin
          // A lock seen in the timeout cycle still wins over the retry.
          if (lock_s) begin
            state_d = STABLE;
            cnt_d   = '0;
          end else if (timeout_hit) begin
            state_d = PLL_RESET;
            cnt_d   = '0;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RUN: begin
          if (!lock_s) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
            if (loss_count != 8'hFF) loss_d = loss_count + 1'b1;
          end
        end
        default: begin
          state_d = PLL_RESET;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so they move on the same edge as state.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= PLL_RESET;
      cnt_q       <= '0;
      pll_resetb  <= 1'b0;
      sys_reset_n <= 1'b0;
      ready       <= 1'b0;
      loss_count  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pll_resetb  <= (state_d != PLL_RESET);
      sys_reset_n <= (state_d == RUN);
      ready       <= (state_d == RUN);
      loss_count  <= loss_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: a cycle model of the sequencing rules checked every
// cycle, plus directed phase-length checks. A small PLL stand-in only locks while RESETB is high.
module tb_pll_reset_sequencer;

  localparam int RESET_CYCLES   = 4;
  localparam int STABLE_CYCLES  = 8;
  localparam int TIMEOUT_CYCLES = 32;
  localparam int CNT_W          = 8;
`ifdef LOCK_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic       clock_in = 1'b0;
  logic       reset_n;
  logic       pll_locked;
  logic       restart_req;
  logic       pll_resetb;
  logic       sys_reset_n;
  logic       ready;
  logic [1:0] state;
  logic [7:0] loss_count;

  bit pll_en;
  int n_tests = 0;
  int n_fail  = 0;

  pll_reset_sequencer #(
    .RESET_CYCLES  (RESET_CYCLES),
    .STABLE_CYCLES (STABLE_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) dut (
    .clock_in   (clock_in),
    .reset_n    (reset_n),
    .pll_locked (pll_locked),
    .restart_req(restart_req),
    .pll_resetb (pll_resetb),
    .sys_reset_n(sys_reset_n),
    .ready      (ready),
    .state      (state),
    .loss_count (loss_count)
  );

  always #5 clock_in = ~clock_in;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: phase 0..3 matches the state output; 'left' counts down the cycles still owed in
  // the reset pulse or the stability window; s1/s2 are the two-cycle view of LOCK.
  typedef struct {
    int phase;
    int left;
    int waited;
    int loss;
    bit s1;
    bit s2;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.phase  = 0;
    r.left   = RESET_CYCLES;
    r.waited = 0;
    r.loss   = 0;
    r.s1     = 1'b0;
    r.s2     = 1'b0;
    return r;
  endfunction

  function automatic model_t model_next(input model_t c, input bit lk, input bit rr);
    model_t n = c;
    bit ls = c.s2;
    n.s2 = c.s1;
    n.s1 = lk;
    if (rr) begin
      n.phase = 0;
      n.left  = RESET_CYCLES;
    end else begin
      case (c.phase)
        0: begin
          n.left = c.left - 1;
          if (n.left == 0) begin
            n.phase  = 1;
            n.waited = 0;
          end
        end
        1: begin
          if (ls) begin
            n.phase = 2;
            n.left  = STABLE_CYCLES;
          end else begin
            n.waited = c.waited + 1;
            if (TIMEOUT_ON && n.waited == TIMEOUT_CYCLES) begin
              n.phase = 0;
              n.left  = RESET_CYCLES;
            end
          end
        end
        2: begin
          if (!ls) begin
            n.phase  = 1;
            n.waited = 0;
          end else begin
            n.left = c.left - 1;
            if (n.left == 0) n.phase = 3;
          end
        end
        default: begin
          if (!ls) begin
            n.phase  = 1;
            n.waited = 0;
            if (c.loss < 255) n.loss = c.loss + 1;
          end
        end
      endcase
    end
    return n;
  endfunction

  always @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) m <= model_reset();
    else          m <= model_next(m, pll_locked, restart_req);
  end

  always @(negedge clock_in) begin
    check("model_state", int'(state), m.phase);
    check("model_pll_resetb", int'(pll_resetb), int'(m.phase != 0));
    check("model_sys_reset_n", int'(sys_reset_n), int'(m.phase == 3));
    check("model_ready", int'(ready), int'(m.phase == 3));
    check("model_loss_count", int'(loss_count), m.loss);
  end

  // Applies the PLL stand-in (locks only while out of reset and enabled), then waits one cycle.
  task automatic tick();
    pll_locked = pll_en & pll_resetb;
    @(negedge clock_in);
  endtask

  task automatic count_until(input logic [1:0] target, input int limit, input int exp_n,
                             input string name);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (state != target && n < limit);
    check(name, n, exp_n);
  endtask

  task automatic bring_up(input string tag);
    restart_req = 1'b1;
    tick();
    restart_req = 1'b0;
    count_until(2'b01, 50, RESET_CYCLES, {tag, "_reset_low"});
    count_until(2'b10, 50, 3, {tag, "_wait_lock"});
    count_until(2'b11, 50, STABLE_CYCLES, {tag, "_stable"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n     = 1'b0;
    restart_req = 1'b0;
    pll_en      = 1'b1;
    pll_locked  = 1'b0;
    repeat (3) tick();
    check("rst_state", int'(state), 0);
    check("rst_pll_resetb", int'(pll_resetb), 0);
    check("rst_sys_reset_n", int'(sys_reset_n), 0);
    check("rst_ready", int'(ready), 0);
    check("rst_loss", int'(loss_count), 0);

    // Power-up: 4 cycles of RESETB low, 2 sync + 1 in WAIT_LOCK, 8 in STABLE.
    reset_n = 1'b1;
    count_until(2'b01, 50, 4, "pwr_reset_low");
    count_until(2'b10, 50, 3, "pwr_wait_lock");
    count_until(2'b11, 50, 8, "pwr_stable");
    check("pwr_sys_reset_n", int'(sys_reset_n), 1);
    check("pwr_ready", int'(ready), 1);
    check("pwr_loss", int'(loss_count), 0);

    // Lock lost in RUN for 3 cycles, then back: 2+1+8 cycles to RUN again.
    pll_en = 1'b0;
    count_until(2'b01, 50, 3, "loss_detect");
    check("loss_sys_reset_n", int'(sys_reset_n), 0);
    check("loss_ready", int'(ready), 0);
    check("loss_count_1", int'(loss_count), 1);
    pll_en = 1'b1;
    count_until(2'b10, 50, 3, "relock_wait");
    count_until(2'b11, 50, 8, "relock_stable");

    // restart_req on the same edge the FSM first sees the lock drop: restart wins.
    pll_en = 1'b0;
    tick();
    tick();
    restart_req = 1'b1;
    tick();
    restart_req = 1'b0;
    check("restart_state", int'(state), 0);
    check("restart_pll_resetb", int'(pll_resetb), 0);
    check("restart_loss", int'(loss_count), 1);
    pll_en = 1'b1;
    count_until(2'b01, 50, 4, "restart_reset_low");
    count_until(2'b10, 50, 3, "restart_wait_lock");

    // One-cycle LOCK glitch seen by STABLE when its count is 5.
    repeat (3) tick();
    pll_en = 1'b0;
    tick();
    pll_en = 1'b1;
    tick();
    tick();
    check("glitch_to_wait", int'(state), 1);
    tick();
    check("glitch_back_stable", int'(state), 2);
    count_until(2'b11, 50, 8, "glitch_full_window");
    check("glitch_loss", int'(loss_count), 1);

    // No lock at all after a restart.
    pll_en      = 1'b0;
    restart_req = 1'b1;
    tick();
    restart_req = 1'b0;
    count_until(2'b01, 50, 4, "nolock_first_pulse");
`ifdef LOCK_TIMEOUT_EN
    count_until(2'b00, 100, 32, "timeout_high_cycles");
    count_until(2'b01, 50, 4, "timeout_retry_pulse");
    count_until(2'b00, 100, 32, "timeout_second_gap");
`else
    count_until(2'b00, 100, 100, "no_timeout_stays_high");
`endif
    pll_en = 1'b1;
    bring_up("recover");

    // Many RUN lock losses: the counter saturates at 255.
    for (int i = 0; i < 260; i++) begin
      pll_en = 1'b0;
      count_until(2'b01, 20, 3, "sat_detect");
      pll_en = 1'b1;
      count_until(2'b11, 40, 11, "sat_reacquire");
    end
    check("sat_loss_255", int'(loss_count), 255);

    // Into STABLE once more, then an asynchronous reset between clock edges.
    pll_en = 1'b0;
    count_until(2'b01, 20, 3, "sat_last_detect");
    check("sat_still_255", int'(loss_count), 255);
    pll_en = 1'b1;
    count_until(2'b10, 20, 3, "midstable_enter");
    tick();
    tick();
    #2 reset_n = 1'b0;
    #1;
    check("async_state", int'(state), 0);
    check("async_pll_resetb", int'(pll_resetb), 0);
    check("async_sys_reset_n", int'(sys_reset_n), 0);
    check("async_ready", int'(ready), 0);
    check("async_loss", int'(loss_count), 0);
    repeat (2) tick();
    reset_n = 1'b1;
    count_until(2'b01, 50, 4, "again_reset_low");
    count_until(2'b10, 50, 3, "again_wait_lock");
    count_until(2'b11, 50, 8, "again_stable");
    check("again_ready", int'(ready), 1);
    check("again_loss", int'(loss_count), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
